// File: rtl/rab_ar_sender.sv
// rab_ar_sender: consumes the RAB lookup FSM's registered decision. Accepted reads go out on the
// master AR channel. Dropped reads are queued in a small FIFO for the error/response generator.
// sent_o pulses for one cycle when the decision has been consumed.
// Optional feature: define RAB_AR_COHERENT_CACHE_EN to derive ARCACHE from cache_coherent_i
// instead of passing the original ARCACHE through.
module rab_ar_sender #(
  parameter int unsigned AXI_M_ADDR_WIDTH = 40,
  parameter int unsigned AXI_ID_WIDTH     = 8,
  parameter int unsigned AXI_USER_WIDTH   = 6,
  parameter int unsigned DROP_FIFO_DEPTH  = 4
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        accept_i,
  input  logic                        drop_i,
  input  logic                        miss_i,
  input  logic                        prefetch_i,
  input  logic [AXI_M_ADDR_WIDTH-1:0] out_addr_i,
  input  logic                        cache_coherent_i,
  input  logic [AXI_ID_WIDTH-1:0]     in_id_i,
  input  logic [7:0]                  in_len_i,
  input  logic [AXI_USER_WIDTH-1:0]   in_user_i,
  input  logic [3:0]                  in_cache_i,
  output logic                        sent_o,
  output logic [AXI_M_ADDR_WIDTH-1:0] m_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     m_ar_id_o,
  output logic [7:0]                  m_ar_len_o,
  output logic [AXI_USER_WIDTH-1:0]   m_ar_user_o,
  output logic [3:0]                  m_ar_cache_o,
  output logic                        m_ar_valid_o,
  input  logic                        m_ar_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     drop_id_o,
  output logic [7:0]                  drop_len_o,
  output logic                        drop_miss_o,
  output logic                        drop_prefetch_o,
  output logic                        drop_valid_o,
  input  logic                        drop_ready_i
);

  localparam int unsigned PtrW   = $clog2(DROP_FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = AXI_ID_WIDTH + 8 + 2;

  typedef enum logic [1:0] {StIdle, StAddr, StGuard} state_e;

  state_e state_q, state_d;
  logic   push, pop, latch, fifo_full;
  logic   [3:0] cache_d;

  logic [EntryW-1:0] mem_q [DROP_FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;

`ifdef RAB_AR_COHERENT_CACHE_EN
  logic [3:0] unused_in_cache;
  assign unused_in_cache = in_cache_i;
  assign cache_d         = {4{cache_coherent_i}};
`else
  logic unused_cache_coherent;
  assign unused_cache_coherent = cache_coherent_i;
  assign cache_d               = in_cache_i;
`endif

  assign fifo_full    = (count_q == CntW'(DROP_FIFO_DEPTH));
  assign drop_valid_o = (count_q != '0);
  assign pop          = drop_valid_o & drop_ready_i;
  assign m_ar_valid_o = (state_q == StAddr);
  assign {drop_id_o, drop_len_o, drop_miss_o, drop_prefetch_o} = mem_q[rptr_q];

  // Decision FSM: drop wins over accept; GUARD gives the FSM one cycle to clear its registers.
  always_comb begin
    state_d = state_q;
    sent_o  = 1'b0;
    push    = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (drop_i) begin
          if (!fifo_full) begin
            push    = 1'b1;
            sent_o  = 1'b1;
            state_d = StGuard;
          end
        end else if (accept_i) begin
          latch   = 1'b1;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (m_ar_ready_i) begin
          sent_o  = 1'b1;
          state_d = StGuard;
        end
      end
      StGuard: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // AR field registers, loaded once on accept and held through the handshake.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      m_ar_addr_o  <= '0;
      m_ar_id_o    <= '0;
      m_ar_len_o   <= '0;
      m_ar_user_o  <= '0;
      m_ar_cache_o <= '0;
    end else if (latch) begin
      m_ar_addr_o  <= out_addr_i;
      m_ar_id_o    <= in_id_i;
      m_ar_len_o   <= in_len_i;
      m_ar_user_o  <= in_user_i;
      m_ar_cache_o <= cache_d;
    end
  end

  // Drop-info FIFO; storage is cleared on reset so the head reads zero afterwards.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < int'(DROP_FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= {in_id_i, in_len_i, miss_i, prefetch_i};
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rab_ar_sender.sv
// Self-checking bench for rab_ar_sender: directed scenarios plus a randomized mix, checked
// against a queue-based model of the drop FIFO and the decision rules.
module tb_rab_ar_sender;
  localparam int AW = 40;
  localparam int IW = 8;
  localparam int UW = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          accept_i, drop_i, miss_i, prefetch_i, cache_coherent_i;
  logic [AW-1:0] out_addr_i;
  logic [IW-1:0] in_id_i;
  logic [7:0]    in_len_i;
  logic [UW-1:0] in_user_i;
  logic [3:0]    in_cache_i;
  logic          sent_o, m_ar_valid_o, m_ar_ready_i;
  logic [AW-1:0] m_ar_addr_o;
  logic [IW-1:0] m_ar_id_o;
  logic [7:0]    m_ar_len_o;
  logic [UW-1:0] m_ar_user_o;
  logic [3:0]    m_ar_cache_o;
  logic [IW-1:0] drop_id_o;
  logic [7:0]    drop_len_o;
  logic          drop_miss_o, drop_prefetch_o, drop_valid_o, drop_ready_i;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [7:0]    len;
    logic          miss;
    logic          pf;
  } drop_t;

  drop_t q[$];
  bit    guard;
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  rab_ar_sender dut (
    .Clk_CI          (clk),
    .Rst_RBI         (rst_n),
    .accept_i        (accept_i),
    .drop_i          (drop_i),
    .miss_i          (miss_i),
    .prefetch_i      (prefetch_i),
    .out_addr_i      (out_addr_i),
    .cache_coherent_i(cache_coherent_i),
    .in_id_i         (in_id_i),
    .in_len_i        (in_len_i),
    .in_user_i       (in_user_i),
    .in_cache_i      (in_cache_i),
    .sent_o          (sent_o),
    .m_ar_addr_o     (m_ar_addr_o),
    .m_ar_id_o       (m_ar_id_o),
    .m_ar_len_o      (m_ar_len_o),
    .m_ar_user_o     (m_ar_user_o),
    .m_ar_cache_o    (m_ar_cache_o),
    .m_ar_valid_o    (m_ar_valid_o),
    .m_ar_ready_i    (m_ar_ready_i),
    .drop_id_o       (drop_id_o),
    .drop_len_o      (drop_len_o),
    .drop_miss_o     (drop_miss_o),
    .drop_prefetch_o (drop_prefetch_o),
    .drop_valid_o    (drop_valid_o),
    .drop_ready_i    (drop_ready_i)
  );

  function automatic drop_t rand_drop();
    drop_t e;
    e.id   = IW'($urandom);
    e.len  = 8'($urandom);
    e.miss = 1'($urandom);
    e.pf   = 1'($urandom);
    return e;
  endfunction

  // One cycle outside the AR handshake: optional drop/accept request and responder pop.
  task automatic drop_step(input bit d, input bit a, input bit r, input drop_t e);
    bit    exp_sent;
    drop_t head;
    drop_i       = d;
    accept_i     = a;
    drop_ready_i = r;
    m_ar_ready_i = 1'b0;
    in_id_i      = e.id;
    in_len_i     = e.len;
    miss_i       = e.miss;
    prefetch_i   = e.pf;
    exp_sent     = !guard && d && (q.size() < DEPTH);
    @(negedge clk);
    tests++;
    if (sent_o !== exp_sent) begin
      fails++;
      $display("FAIL drop_sent: got %b want %b", sent_o, exp_sent);
    end
    tests++;
    if (m_ar_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL drop_arvalid: got %b want 0", m_ar_valid_o);
    end
    tests++;
    if (drop_valid_o !== (q.size() != 0)) begin
      fails++;
      $display("FAIL drop_valid: got %b want %b", drop_valid_o, q.size() != 0);
    end
    if (q.size() != 0) begin
      head = q[0];
      tests++;
      if ({drop_id_o, drop_len_o, drop_miss_o, drop_prefetch_o} !== head) begin
        fails++;
        $display("FAIL drop_head: got %h want %h",
                 {drop_id_o, drop_len_o, drop_miss_o, drop_prefetch_o}, head);
      end
    end
    @(posedge clk);
    if (r && q.size() != 0) head = q.pop_front();
    if (exp_sent) q.push_back(e);
    guard = exp_sent;
    #1;
    drop_i   = 1'b0;
    accept_i = 1'b0;
  endtask

  // Full accept transaction with `stall` cycles of ARREADY low; inputs scrambled after latch.
  task automatic do_accept(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                           input logic [7:0] len, input logic [UW-1:0] user,
                           input logic [3:0] cache, input bit coh, input int stall);
    logic [3:0] exp_cache;
    if (guard) drop_step(1'b0, 1'b0, 1'b0, '0);
`ifdef RAB_AR_COHERENT_CACHE_EN
    exp_cache = coh ? 4'b1111 : 4'b0000;
`else
    exp_cache = cache;
`endif
    accept_i = 1'b1; drop_i = 1'b0; drop_ready_i = 1'b0;
    out_addr_i = addr; in_id_i = id; in_len_i = len; in_user_i = user;
    in_cache_i = cache; cache_coherent_i = coh;
    m_ar_ready_i = (stall == 0);
    @(negedge clk);
    tests++;
    if ({sent_o, m_ar_valid_o} !== 2'b00) begin
      fails++;
      $display("FAIL acc_first: sent/valid got %b want 00", {sent_o, m_ar_valid_o});
    end
    @(posedge clk); #1;
    out_addr_i = AW'({$urandom, $urandom}); in_id_i = IW'($urandom);
    in_len_i = 8'($urandom); in_user_i = UW'($urandom); in_cache_i = 4'($urandom);
    cache_coherent_i = ~coh;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      tests++;
      if ({sent_o, m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_user_o, m_ar_cache_o}
          !== {2'b01, addr, id, len, user, exp_cache}) begin
        fails++;
        $display("FAIL acc_hold: got %b %b %h %h %h %h %h want 0 1 %h %h %h %h %h", sent_o,
                 m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_user_o, m_ar_cache_o,
                 addr, id, len, user, exp_cache);
      end
      @(posedge clk); #1;
      if (i == stall - 1) m_ar_ready_i = 1'b1;
    end
    @(negedge clk);
    tests++;
    if ({sent_o, m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_user_o, m_ar_cache_o}
        !== {2'b11, addr, id, len, user, exp_cache}) begin
      fails++;
      $display("FAIL acc_hs: got %b %b %h %h %h %h %h want 1 1 %h %h %h %h %h", sent_o,
               m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_user_o, m_ar_cache_o,
               addr, id, len, user, exp_cache);
    end
    @(posedge clk); #1;
    accept_i = 1'b0; m_ar_ready_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({sent_o, m_ar_valid_o} !== 2'b00) begin
      fails++;
      $display("FAIL acc_guard: sent/valid got %b want 00", {sent_o, m_ar_valid_o});
    end
    @(posedge clk); #1;
    guard = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    accept_i = 0; drop_i = 0; miss_i = 0; prefetch_i = 0; cache_coherent_i = 0;
    out_addr_i = '0; in_id_i = '0; in_len_i = '0; in_user_i = '0; in_cache_i = '0;
    m_ar_ready_i = 0; drop_ready_i = 0;
    q.delete(); guard = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({sent_o, m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_user_o, m_ar_cache_o,
         drop_valid_o, drop_id_o, drop_len_o, drop_miss_o, drop_prefetch_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got nonzero, want all 0 (arvalid %b dvalid %b addr %h)",
               m_ar_valid_o, drop_valid_o, m_ar_addr_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_accept();
    do_accept(40'h12_3456_7000, 8'h05, 8'd3, 6'h2a, 4'h3, 1'b0, 0);
    do_accept(AW'({$urandom, $urandom}), 8'h9c, 8'd15, 6'h11, 4'ha, 1'b1, 5);
  endtask

  task automatic test_fill();
    drop_t e;
    for (int i = 1; i <= 4; i++) begin
      e = '{id: IW'(i), len: 8'($urandom), miss: 1'b1, pf: 1'b0};
      drop_step(1'b1, 1'b0, 1'b0, e);
      drop_step(1'b0, 1'b0, 1'b0, '0);
    end
    e = '{id: 8'd5, len: 8'h44, miss: 1'b1, pf: 1'b1};
    drop_step(1'b1, 1'b0, 1'b0, e);  // full: stall
    drop_step(1'b1, 1'b0, 1'b0, e);
    drop_step(1'b1, 1'b0, 1'b1, e);  // pop while full: push still refused
    drop_step(1'b1, 1'b0, 1'b0, e);  // push now
    drop_step(1'b1, 1'b0, 1'b0, e);  // guard cycle ignores drop_i
    drop_step(1'b1, 1'b0, 1'b0, e);  // full again: stall
    for (int n = 0; n < 10 && q.size() != 0; n++) drop_step(1'b0, 1'b0, 1'b1, '0);
    drop_step(1'b0, 1'b0, 1'b1, '0);  // pop on empty FIFO has no effect
  endtask

  task automatic test_rst_midburst();
    drop_step(1'b1, 1'b0, 1'b0, rand_drop());
    drop_step(1'b0, 1'b0, 1'b0, '0);
    drop_step(1'b1, 1'b0, 1'b0, rand_drop());
    drop_step(1'b0, 1'b0, 1'b0, '0);
    accept_i = 1'b1; m_ar_ready_i = 1'b0; drop_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({m_ar_valid_o, drop_valid_o} !== 2'b11) begin
      fails++;
      $display("FAIL rst_pre: arvalid/dvalid got %b want 11", {m_ar_valid_o, drop_valid_o});
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({sent_o, m_ar_valid_o, drop_valid_o, drop_id_o, drop_len_o, m_ar_addr_o} !== '0) begin
      fails++;
      $display("FAIL rst_async: sent/arvalid/dvalid got %b%b%b want 000",
               sent_o, m_ar_valid_o, drop_valid_o);
    end
    accept_i = 1'b0;
    q.delete(); guard = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_accept(AW'({$urandom, $urandom}), 8'h3c, 8'd7, 6'h05, 4'h6, 1'b0, 1);
  endtask

  task automatic test_both();
    drop_step(1'b1, 1'b1, 1'b0, rand_drop());
    drop_step(1'b1, 1'b1, 1'b0, rand_drop());  // guard: both ignored
    drop_step(1'b0, 1'b0, 1'b1, '0);
    do_accept(AW'({$urandom, $urandom}), 8'h77, 8'd1, 6'h3f, 4'h2, 1'b1, 0);
    do_accept(AW'({$urandom, $urandom}), 8'h78, 8'd2, 6'h01, 4'hd, 1'b0, 2);
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: do_accept(AW'({$urandom, $urandom}), IW'($urandom), 8'($urandom), UW'($urandom),
                     4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        1: begin
          drop_t e;
          int    n;
          e = rand_drop();
          if (guard) drop_step(1'b0, 1'b0, 1'($urandom), '0);
          n = 0;
          while (!guard && n < 40) begin
            drop_step(1'b1, 1'($urandom), 1'($urandom_range(0, 3) == 0), e);
            n++;
          end
          tests++;
          if (!guard) begin
            fails++;
            $display("FAIL rand_drop_timeout: pushed 0 want 1 within 40 cycles");
          end
        end
        default: drop_step(1'b0, 1'b0, 1'($urandom), '0);
      endcase
    end
    for (int n = 0; n < 10 && q.size() != 0; n++) drop_step(1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    test_reset();
    test_accept();
    test_fill();
    test_rst_midburst();
    test_both();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
